// File: rtl/regfile_arb_pkg.sv
// Shared types for the regfile write arbiter.
// Defaults for data/address width, requester ids and the buffered entry.
package regfile_arb_pkg;

    localparam int ARB_WIDTH  = 32;
    localparam int ARB_ADDR_W = 5;
    localparam int ARB_DEPTH  = 2;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_WIDTH-1:0]  data;
    } wb_entry_t;

    function automatic logic is_zero_reg(
        input logic [ARB_ADDR_W-1:0] addr
    );
        return addr == '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO buffering one writeback requester.
// Ports: Clk, Rst_n, push/push_data in, pop in, full/empty/head out.
module wb_fifo
    import regfile_arb_pkg::*;
#(
    parameter int  DEPTH   = ARB_DEPTH,
    parameter type entry_t = wb_entry_t
) (
    input  logic   Clk,
    input  logic   Rst_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    entry_t         mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    // A full FIFO refuses a push even when it pops in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between the ALU (A) and load (B) paths.
// Ports: Clk, Rst_n; A_/B_ Valid/Ready/Addr/Data; RegWrite, WriteRegister,
// WriteData, Conflict, Idle. Define FIXED_PRIO_EN for A-first priority.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int WIDTH  = ARB_WIDTH,
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DEPTH  = ARB_DEPTH
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              A_Valid,
    output logic              A_Ready,
    input  logic [ADDR_W-1:0] A_Addr,
    input  logic [WIDTH-1:0]  A_Data,
    input  logic              B_Valid,
    output logic              B_Ready,
    input  logic [ADDR_W-1:0] B_Addr,
    input  logic [WIDTH-1:0]  B_Data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [WIDTH-1:0]  WriteData,
    output logic              Conflict,
    output logic              Idle
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } entry_t;

    entry_t a_in;
    entry_t b_in;
    entry_t a_head;
    entry_t b_head;
    entry_t g_head;
    logic   a_full;
    logic   a_empty;
    logic   b_full;
    logic   b_empty;
    logic   a_push;
    logic   b_push;
    logic   gnt_a;
    logic   gnt_b;

`ifndef FIXED_PRIO_EN
    req_id_t last_grant;
`endif

    assign a_in    = '{addr: A_Addr, data: A_Data};
    assign b_in    = '{addr: B_Addr, data: B_Data};
    assign A_Ready = !a_full;
    assign B_Ready = !b_full;
    assign a_push  = A_Valid && A_Ready;
    assign b_push  = B_Valid && B_Ready;

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo_a (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .push      (a_push),
        .push_data (a_in),
        .pop       (gnt_a),
        .full      (a_full),
        .empty     (a_empty),
        .head      (a_head)
    );

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo_b (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .push      (b_push),
        .push_data (b_in),
        .pop       (gnt_b),
        .full      (b_full),
        .empty     (b_empty),
        .head      (b_head)
    );

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        unique case (1'b1)
            (!a_empty && !b_empty): begin
`ifdef FIXED_PRIO_EN
                gnt_a = 1'b1;
`else
                // Whoever was not served last time goes now.
                gnt_a = (last_grant == REQ_B);
                gnt_b = (last_grant == REQ_A);
`endif
            end
            (!a_empty && b_empty): gnt_a = 1'b1;
            (a_empty && !b_empty): gnt_b = 1'b1;
            default: ;
        endcase
    end

    assign g_head = gnt_a ? a_head : b_head;

    // Register 0 entries are consumed and loaded but never enabled.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else if (gnt_a || gnt_b) begin
            RegWrite      <= (g_head.addr != '0);
            WriteRegister <= g_head.addr;
            WriteData     <= g_head.data;
        end else begin
            RegWrite      <= 1'b0;
        end
    end

`ifndef FIXED_PRIO_EN
    // Reset to B so that A wins the first contended cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_grant <= REQ_B;
        end else if (gnt_a) begin
            last_grant <= REQ_A;
        end else if (gnt_b) begin
            last_grant <= REQ_B;
        end
    end
`endif

    assign Conflict = !a_empty && !b_empty
                   && (a_head.addr == b_head.addr)
                   && (a_head.addr != '0);

    assign Idle = a_empty && b_empty && !RegWrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter.
// Queue-based reference model with directed and random stimulus.
module tb_regfile_write_arbiter;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int D  = 2;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } ent_t;

    logic          Clk;
    logic          Rst_n;
    logic          A_Valid;
    logic          A_Ready;
    logic [AW-1:0] A_Addr;
    logic [W-1:0]  A_Data;
    logic          B_Valid;
    logic          B_Ready;
    logic [AW-1:0] B_Addr;
    logic [W-1:0]  B_Data;
    logic          RegWrite;
    logic [AW-1:0] WriteRegister;
    logic [W-1:0]  WriteData;
    logic          Conflict;
    logic          Idle;

    int vectors = 0;
    int miscompares = 0;

    ent_t          qa [$];
    ent_t          qb [$];
    bit            m_last_b = 1'b1;
    logic          exp_rw = 1'b0;
    logic [AW-1:0] exp_wr = '0;
    logic [W-1:0]  exp_wd = '0;
    logic [W-1:0]  mrf [32] = '{default: '0};
    logic [W-1:0]  rf  [32] = '{default: '0};

    regfile_write_arbiter #(
        .WIDTH  (W),
        .ADDR_W (AW),
        .DEPTH  (D)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .A_Valid       (A_Valid),
        .A_Ready       (A_Ready),
        .A_Addr        (A_Addr),
        .A_Data        (A_Data),
        .B_Valid       (B_Valid),
        .B_Ready       (B_Ready),
        .B_Addr        (B_Addr),
        .B_Data        (B_Data),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .Conflict      (Conflict),
        .Idle          (Idle)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Register file fed by the DUT's write port.
    always @(posedge Clk) begin
        if (RegWrite && WriteRegister != '0) begin
            rf[WriteRegister] <= WriteData;
        end
    end

    task automatic chk(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit av, input int aa, input int ad,
                         input bit bv, input int ba, input int bd);
        A_Valid = av;
        A_Addr  = AW'(aa);
        A_Data  = W'(ad);
        B_Valid = bv;
        B_Addr  = AW'(ba);
        B_Data  = W'(bd);
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_last_b = 1'b1;
        exp_rw   = 1'b0;
        exp_wr   = '0;
        exp_wd   = '0;
    endtask

    // Called just after a rising edge with inputs already applied.
    task automatic cycle();
        bit   ar;
        bit   br;
        bit   conf;
        bit   take_a;
        bit   take_b;
        ent_t h;
        ar   = (qa.size() < D);
        br   = (qb.size() < D);
        conf = 1'b0;
        if (qa.size() > 0 && qb.size() > 0) begin
            conf = (qa[0].a == qb[0].a) && (qa[0].a != 0);
        end
        chk("A_Ready", W'(A_Ready), W'(ar));
        chk("B_Ready", W'(B_Ready), W'(br));
        chk("Conflict", W'(Conflict), W'(conf));
        chk("Idle", W'(Idle),
            W'(qa.size() == 0 && qb.size() == 0 && !exp_rw));
        if (exp_rw && exp_wr != 0) mrf[exp_wr] = exp_wd;
        take_a = 1'b0;
        take_b = 1'b0;
        if (qa.size() > 0 && qb.size() > 0) begin
`ifdef FIXED_PRIO_EN
            take_a = 1'b1;
`else
            take_a = m_last_b;
            take_b = !m_last_b;
`endif
        end else begin
            take_a = (qa.size() > 0);
            take_b = (qb.size() > 0);
        end
        if (take_a || take_b) begin
            h = take_a ? qa.pop_front() : qb.pop_front();
            m_last_b = take_b;
            exp_rw = (h.a != 0);
            exp_wr = h.a;
            exp_wd = h.d;
        end else begin
            exp_rw = 1'b0;
        end
        if (A_Valid && ar) qa.push_back('{a: A_Addr, d: A_Data});
        if (B_Valid && br) qb.push_back('{a: B_Addr, d: B_Data});
        @(posedge Clk);
        #1;
        chk("RegWrite", W'(RegWrite), W'(exp_rw));
        chk("WriteRegister", W'(WriteRegister), W'(exp_wr));
        chk("WriteData", WriteData, exp_wd);
    endtask

    task automatic idle_cycles(input int n);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        Rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_rw", W'(RegWrite), 0);
        chk("rst_wr", W'(WriteRegister), 0);
        chk("rst_wd", WriteData, 0);
        chk("rst_idle", W'(Idle), 1);
        Rst_n = 1'b1;
        idle_cycles(2);

        // A-only write with two-edge latency
        drive(1, 2, 42, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        chk("t2_rw", W'(RegWrite), 1);
        chk("t2_wr", W'(WriteRegister), 2);
        chk("t2_wd", WriteData, 42);
        cycle();
        chk("t2_rf", rf[2], 42);

        // Zero register is consumed, never written
        drive(1, 0, 15, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        chk("t5_rw", W'(RegWrite), 0);
        cycle();
        chk("t5_rf0", rf[0], 0);

        // Same nonzero register at both heads
        drive(1, 3, 19, 1, 3, 20);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("t6_conf", W'(Conflict), 1);
        cycle();
`ifdef FIXED_PRIO_EN
        chk("t6_first", WriteData, 19);
`endif
        idle_cycles(3);

        // Contention: both stream every cycle
        drive(1, 5, 7, 1, 6, 9);
        for (int i = 0; i < 8; i++) cycle();
        idle_cycles(4);

        // B bursts into a full FIFO while A streams
        for (int i = 0; i < 3; i++) begin
            drive(1, 10 + i, 100 + i, 1, 20 + i, 200 + i);
            cycle();
        end
        drive(1, 13, 103, 0, 0, 0);
        cycle();
        idle_cycles(5);

        // Reset with two entries queued
        drive(1, 7, 77, 1, 8, 88);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        Rst_n = 1'b0;
        #1;
        chk("t1_rw", W'(RegWrite), 0);
        chk("t1_idle", W'(Idle), 1);
        model_reset();
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        idle_cycles(4);
        chk("t1_rf7", rf[7], 0);
        chk("t1_rf8", rf[8], 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom);
            cycle();
        end
        idle_cycles(6);

        for (int r = 0; r < 32; r++) begin
            chk($sformatf("rf%0d", r), rf[r], mrf[r]);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
